// File: rtl/pet_io_slot_arbiter.sv
// Purpose: shares the PET E8xx I/O register bus between the 6502 and a secondary (host/debug) requester.
// Latency: a secondary access waits for an idle CE slot (or steals one after MAX_WAIT denials); ack 2 clk after the slot.
// Backpressure: the CPU is held off only by one withheld clock enable per stolen slot; dbg_req while busy is dropped.
module pet_io_slot_arbiter #(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    output logic       cpu_ce,
    input  logic       cpu_cs,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [7:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_busy,
    output logic       dbg_ack,
    output logic [7:0] dbg_rdata,
    output logic       dbg_stole,
    output logic       io_cs,
    output logic       io_we,
    output logic [7:0] io_addr,
    output logic [7:0] io_wdata,
    input  logic [7:0] io_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DATA = 2'd2,
        ACK  = 2'd3
    } state_t;

    // Wait counter compare is done one bit wider so MAX_WAIT near 2^WAIT_W never wraps.
    localparam logic [WAIT_W:0] MAX_WAIT_X = (WAIT_W + 1)'(MAX_WAIT);
    localparam logic [WAIT_W:0] ONE_X      = (WAIT_W + 1)'(1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              steal;
    logic              req_we;
    logic [7:0]        req_addr;
    logic [7:0]        req_wdata;

    logic              in_wait;
    logic              steal_slot;
    logic              sec_slot;
    logic [WAIT_W:0]   cnt_inc;

    assign in_wait    = (state == WAIT);
    // A stolen slot withholds the CPU's enable whether or not ce is high, so
    // the CPU never sees the enable belonging to the stolen slot.
    assign steal_slot = steal & in_wait;
    // Secondary owns the slot when it is stealing, or when the CPU is off the I/O bus.
    assign sec_slot   = ce & in_wait & (steal | ~cpu_cs);
    assign cnt_inc    = {1'b0, wait_cnt} + ONE_X;

    assign cpu_ce = ce & ~steal_slot;

    // I/O bus mux: latched request only on the secondary's slot clk, CPU otherwise.
    always_comb begin
        io_cs    = cpu_cs;
        io_we    = cpu_we;
        io_addr  = cpu_addr;
        io_wdata = cpu_wdata;
        if (sec_slot) begin
            io_cs    = 1'b1;
            io_we    = req_we;
            io_addr  = req_addr;
            io_wdata = req_wdata;
        end
    end

    // Request FSM: accept, wait for a slot (counting denials), capture read data, ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            steal     <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= 8'h00;
            req_wdata <= 8'h00;
            dbg_busy  <= 1'b0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= 8'hFF;
            dbg_stole <= 1'b0;
        end else begin
            dbg_ack   <= 1'b0;
            dbg_stole <= 1'b0;
            case (state)
                IDLE: begin
                    // Entering WAIT on this edge means a same-clk ce slot was
                    // already evaluated in IDLE, so the request starts at the next ce.
                    if (dbg_req) begin
                        req_we    <= dbg_we;
                        req_addr  <= dbg_addr;
                        req_wdata <= dbg_wdata;
                        dbg_busy  <= 1'b1;
                        wait_cnt  <= '0;
                        steal     <= (MAX_WAIT == 0);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (sec_slot) begin
                        dbg_stole <= steal;
                        steal     <= 1'b0;
                        state     <= DATA;
                    end else if (ce && cpu_cs) begin
                        if (wait_cnt != {WAIT_W{1'b1}}) begin
                            wait_cnt <= cnt_inc[WAIT_W-1:0];
                        end
                        if (cnt_inc == MAX_WAIT_X) begin
                            steal <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    // The I/O block's registered read data is valid on this clk.
                    dbg_rdata <= req_we ? 8'hFF : io_rdata;
                    dbg_ack   <= 1'b1;
                    state     <= ACK;
                end
                ACK: begin
                    dbg_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
